// File: rtl/cache_parameters.sv
// Cache block-transfer types shared by the cache controller and the memory responder.
package cache_parameters;
  import memory_mapping::*;

  localparam int BLOCK_SIZE   = 2;
  localparam int OFFSET_WIDTH = clog2(BLOCK_SIZE);

  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  cs;
    logic                  rw;    // 0 read (allocate), 1 write (write_back)
    block_t                data;
  } memory_request_t;

  typedef struct packed {
    logic   ack;
    block_t data;
  } memory_response_t;

  typedef enum logic [2:0] {
    mr_idle,
    mr_wait,
    mr_xfer,
    mr_last,
    mr_ack,
    mr_release
  } mem_resp_state_t;

endpackage

// File: rtl/memory_mapping.sv
// Word and address geometry shared by the cache and its memory-side blocks.
package memory_mapping;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  // Ceiling log2 that can be evaluated at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM with a registered read port (1-cycle latency).
module word_ram #(
  parameter int    WORDS     = 1024,
  parameter int    WIDTH     = 32,
  parameter int    AW        = 10,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // NOTE: the storage array is deliberately not reset; only a preload image may initialise it.
  logic [WIDTH-1:0] mem_q [WORDS];

  // NOTE: sequential state is always updated with <=, so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: serves whole-block reads and writes from on-chip RAM after
// LATENCY wait states, completing each request with a one-cycle ack and 4-phase release.
module cache_mem_responder
  import memory_mapping::*;
  import cache_parameters::*;
#(
  parameter int    LATENCY   = 2,
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  memory_request_t  mem_req_i,
  output memory_response_t mem_resp_o,
  output logic             busy_o
);

  localparam int AW     = clog2(MEM_WORDS);
  localparam int WAIT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

  mem_resp_state_t         state_q, state_d;
  logic [AW-1:0]           base_q, base_d;
  logic                    rw_q, rw_d;
  block_t                  wdata_q, wdata_d;
  block_t                  resp_q, resp_d;
  logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;

  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [WORD_WIDTH-1:0] ram_wdata;
  logic [WORD_WIDTH-1:0] ram_rdata;

  // Address bits above the RAM depth and the in-block offset never reach the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_req_i.addr;

  word_ram #(
    .WORDS    (MEM_WORDS),
    .WIDTH    (WORD_WIDTH),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= mr_idle;
      base_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    ram_we    = 1'b0;
    ram_addr  = base_q | AW'(beat_q);
    ram_wdata = wdata_q[beat_q];

    case (state_q)
      mr_idle: begin
        if (mem_req_i.cs) begin
          base_d  = {mem_req_i.addr[AW-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
          rw_d    = mem_req_i.rw;
          if (mem_req_i.rw) wdata_d = mem_req_i.data;
          beat_d  = '0;
          wait_d  = '0;
          state_d = (LATENCY == 0) ? mr_xfer : mr_wait;
        end
      end
      mr_wait: begin
        if (int'(wait_q) == LATENCY - 1) state_d = mr_xfer;
        else                             wait_d  = wait_q + 1'b1;
      end
      mr_xfer: begin
        ram_we = rw_q;
        // Read data lags the address by one beat, so beat k lands word k-1.
        if (!rw_q && beat_q != '0) resp_d[beat_q - 1'b1] = ram_rdata;
        if (beat_q == OFFSET_WIDTH'(BLOCK_SIZE - 1)) state_d = mr_last;
        else                                         beat_d  = beat_q + 1'b1;
      end
      mr_last: begin
        if (!rw_q) resp_d[BLOCK_SIZE-1] = ram_rdata;
        state_d = mr_ack;
      end
      mr_ack:     state_d = mr_release;
      mr_release: if (!mem_req_i.cs) state_d = mr_idle;
      default:    state_d = mr_idle;
    endcase
  end

  assign mem_resp_o.ack  = (state_q == mr_ack);
  assign mem_resp_o.data = resp_q;
  assign busy_o          = (state_q != mr_idle);

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench: a LATENCY=2 and a LATENCY=0 responder driven by directed transfers.
module tb_cache_mem_responder;
  import memory_mapping::*;
  import cache_parameters::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  memory_request_t  req2, req0;
  memory_response_t resp2, resp0;
  logic             busy2, busy0;

  typedef struct {
    int     cyc;
    block_t data;
  } exp_t;

  exp_t   q2[$];
  exp_t   q0[$];
  block_t last_rd[2];
  exp_t   m2, m0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_responder #(.LATENCY(2), .MEM_WORDS(1024), .INIT_FILE("")) dut_l2 (
    .clk(clk), .rst(rst), .mem_req_i(req2), .mem_resp_o(resp2), .busy_o(busy2)
  );

  cache_mem_responder #(.LATENCY(0), .MEM_WORDS(1024), .INIT_FILE("")) dut_l0 (
    .clk(clk), .rst(rst), .mem_req_i(req0), .mem_resp_o(resp0), .busy_o(busy0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic block_t blk(input logic [31:0] w0, input logic [31:0] w1);
    block_t r;
    r[0] = w0;
    r[1] = w1;
    return r;
  endfunction

  // Monitor: every ack must match the oldest expected response, in cycle and in data.
  always @(posedge clk) begin
    #1;
    if (resp2.ack) begin
      if (q2.size() == 0) check("l2_spurious_ack", 64'd1, 64'd0);
      else begin
        m2 = q2.pop_front();
        check("l2_ack_cycle", 64'(cyc), 64'(m2.cyc));
        check("l2_resp_data", resp2.data, m2.data);
      end
    end
    if (resp0.ack) begin
      if (q0.size() == 0) check("l0_spurious_ack", 64'd1, 64'd0);
      else begin
        m0 = q0.pop_front();
        check("l0_ack_cycle", 64'(cyc), 64'(m0.cyc));
        check("l0_resp_data", resp0.data, m0.data);
      end
    end
  end

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy2 : busy0;
  endfunction

  function automatic logic get_ack(input int sel);
    return (sel == 0) ? resp2.ack : resp0.ack;
  endfunction

  task automatic drive(input int sel, input logic [31:0] addr, input logic cs,
                       input logic rw, input block_t data);
    memory_request_t r;
    r.addr = addr;
    r.cs   = cs;
    r.rw   = rw;
    r.data = data;
    if (sel == 0) req2 = r;
    else          req0 = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 4-phase transfer; expected response is queued when cs is raised.
  task automatic xact(input int sel, input logic [31:0] addr, input logic rw,
                      input block_t wdata, input block_t exp_rd, input int hold);
    exp_t e;
    int   lat;
    lat = (sel == 0) ? 2 : 0;
    check("idle_before_req", 64'(get_busy(sel)), 64'd0);
    drive(sel, addr, 1'b1, rw, rw ? wdata : ~wdata);
    e.cyc = cyc + 1 + lat + BLOCK_SIZE + 1;
    if (rw) e.data = last_rd[sel];
    else begin
      e.data       = exp_rd;
      last_rd[sel] = exp_rd;
    end
    if (sel == 0) q2.push_back(e);
    else          q0.push_back(e);
    tick();
    check("busy_after_accept", 64'(get_busy(sel)), 64'd1);
    // Scramble the request while busy; the latched copy must be used.
    drive(sel, ~addr, 1'b1, ~rw, ~wdata);
    for (int i = 0; i < 40 && !get_ack(sel); i++) tick();
    check("ack_seen", 64'(get_ack(sel)), 64'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("busy_in_release", 64'(get_busy(sel)), 64'd1);
    end
    drive(sel, 32'h0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 10 && get_busy(sel); i++) tick();
    check("idle_after_release", 64'(get_busy(sel)), 64'd0);
  endtask

  localparam logic [31:0] BLK_ADDR [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
  localparam logic [31:0] BLK_W0   [4] = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
  localparam logic [31:0] BLK_W1   [4] = '{32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 32'h4444_0001};

  initial begin
    last_rd[0] = '0;
    last_rd[1] = '0;
    drive(0, 32'h0, 1'b0, 1'b0, '0);
    drive(1, 32'h0, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_ack_l2",  64'(resp2.ack), 64'd0);
    check("rst_busy_l2", 64'(busy2), 64'd0);
    check("rst_data_l2", resp2.data, 64'd0);
    check("rst_ack_l0",  64'(resp0.ack), 64'd0);
    check("rst_busy_l0", 64'(busy0), 64'd0);
    check("rst_data_l0", resp0.data, 64'd0);

    // Write then read back one block.
    xact(0, 32'h040, 1'b1, blk(32'hDEADBEEF, 32'h01234567), '0, 0);
    xact(0, 32'h040, 1'b0, '0, blk(32'hDEADBEEF, 32'h01234567), 0);

    // Offset masking and upper-bit aliasing.
    xact(0, 32'h081, 1'b1, blk(32'hA, 32'hB), '0, 0);
    xact(0, 32'h080, 1'b0, '0, blk(32'hA, 32'hB), 0);
    xact(0, 32'h480, 1'b0, '0, blk(32'hA, 32'hB), 0);

    // cs held high after ack: one ack only, then a fresh request.
    xact(0, 32'h040, 1'b0, '0, blk(32'hDEADBEEF, 32'h01234567), 10);
    xact(0, 32'h080, 1'b0, '0, blk(32'hA, 32'hB), 0);

    // Reset during XFER of a read, with cs still high on the reset edge.
    drive(0, 32'h040, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick();
    check("abort_in_xfer_busy", 64'(busy2), 64'd1);
    rst = 1'b1;
    tick();
    check("abort_ack",  64'(resp2.ack), 64'd0);
    check("abort_busy", 64'(busy2), 64'd0);
    check("abort_data", resp2.data, 64'd0);
    rst = 1'b0;
    drive(0, 32'h0, 1'b0, 1'b0, '0);
    last_rd[0] = '0;
    tick();
    check("abort_stays_idle", 64'(busy2), 64'd0);
    xact(0, 32'h080, 1'b0, '0, blk(32'hA, 32'hB), 0);

    // Zero-latency instance: single block, then alternating write/read over four blocks.
    xact(1, 32'h100, 1'b1, blk(32'h1, 32'h2), '0, 0);
    xact(1, 32'h100, 1'b0, '0, blk(32'h1, 32'h2), 0);
    for (int b = 0; b < 4; b++) begin
      xact(1, BLK_ADDR[b], 1'b1, blk(BLK_W0[b], BLK_W1[b]), '0, 0);
      xact(1, BLK_ADDR[b], 1'b0, '0, blk(BLK_W0[b], BLK_W1[b]), 0);
    end
    for (int b = 3; b >= 0; b--)
      xact(1, BLK_ADDR[b] | 32'h1, 1'b0, '0, blk(BLK_W0[b], BLK_W1[b]), 0);

    tick();
    tick();
    check("l2_queue_drained", 64'(q2.size()), 64'd0);
    check("l0_queue_drained", 64'(q0.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
